// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: op-code constants and FSM state encoding shared by the logic unit files.
package logic_unit_pkg;
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_ROL  = 3'b110;
    localparam logic [2:0] OP_ROR  = 3'b111;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/logic_core.sv
// logic_core: combinational bitwise ops and single-bit rotate step.
// Ports: op_i/a_i/b_i -> bit_o (six bitwise ops); rot_src_i, dir_left_i -> rot_o (rotate by one bit).
module logic_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] rot_src_i,
    input  logic             dir_left_i,
    output logic [WIDTH-1:0] bit_o,
    output logic [WIDTH-1:0] rot_o
);
    always_comb begin
        bit_o = '0;
        case (op_i)
            OP_AND:  bit_o = a_i & b_i;
            OP_OR:   bit_o = a_i | b_i;
            OP_XOR:  bit_o = a_i ^ b_i;
            OP_NOT:  bit_o = ~a_i;
            OP_NAND: bit_o = ~(a_i & b_i);
            OP_NOR:  bit_o = ~(a_i | b_i);
            default: bit_o = '0;
        endcase
    end
    assign rot_o = dir_left_i ? {rot_src_i[WIDTH-2:0], rot_src_i[WIDTH-1]}
                              : {rot_src_i[0], rot_src_i[WIDTH-1:1]};
endmodule

// File: rtl/logical_unit_seq.sv
// logical_unit_seq: registered logic unit with start/done handshake; rotates step one bit per cycle.
// Ports: clk, rst (async, active high); start/op/a/b/shamt request inputs;
// busy (rotate in progress), done (1-cycle valid pulse), result, zero (result==0).
// Optional macro LOGIC_UNIT_PARITY_EN adds output parity = ^result, registered with result.
module logical_unit_seq
    import logic_unit_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
`ifdef LOGIC_UNIT_PARITY_EN
    output logic             parity,
`endif
    output logic             zero
);
    state_t           state_q, state_d;
    logic [SHW-1:0]   count_q, count_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             parity_q, parity_d;
    logic [WIDTH-1:0] bit_res, rot_res;
    logic             accept, is_rot, write;

    logic_core #(.WIDTH(WIDTH)) u_core (
        .op_i      (op),
        .a_i       (a),
        .b_i       (b),
        .rot_src_i (result_q),
        .dir_left_i(dir_q),
        .bit_o     (bit_res),
        .rot_o     (rot_res)
    );

    assign accept = start && (state_q != ROT);
    assign is_rot = (op == OP_ROL) || (op == OP_ROR);
    // zero/parity track every result write, including intermediate rotate steps
    assign write  = accept || (state_q == ROT);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        dir_d    = dir_q;
        result_d = result_q;
        if (accept) begin
            dir_d    = (op == OP_ROL);
            count_d  = shamt;
            result_d = is_rot ? a : bit_res;
            state_d  = (is_rot && shamt != '0) ? ROT : DONE;
        end else if (state_q == ROT) begin
            result_d = rot_res;
            count_d  = count_q - 1'b1;
            state_d  = (count_q == SHW'(1)) ? DONE : ROT;
        end else if (state_q == DONE) begin
            state_d  = IDLE;
        end
        zero_d   = write ? (result_d == '0) : zero_q;
        parity_d = write ? ^result_d : parity_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            dir_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            dir_q    <= dir_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            parity_q <= parity_d;
        end
    end

    assign busy   = (state_q == ROT);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign zero   = zero_q;
`ifdef LOGIC_UNIT_PARITY_EN
    assign parity = parity_q;
`else
    logic unused_parity;
    assign unused_parity = parity_q;
`endif
endmodule

// File: tb/tb_logical_unit_seq.sv
// tb_logical_unit_seq: directed and randomized checks of logical_unit_seq against a behavioural model.
module tb_logical_unit_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] op = '0;
    logic [7:0] a = '0, b = '0;
    logic [2:0] shamt = '0;
    logic       busy, done, zero;
    logic [7:0] result;
`ifdef LOGIC_UNIT_PARITY_EN
    logic       parity;
`endif
    int checks = 0;
    int errors = 0;

    logical_unit_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .shamt(shamt),
        .busy(busy), .done(done), .result(result),
`ifdef LOGIC_UNIT_PARITY_EN
        .parity(parity),
`endif
        .zero(zero)
    );

    always #5 clk = ~clk;

    // Reference: rotates as a true circular shift by (s mod 8), computed arithmetically.
    function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                                         input logic [2:0] s);
        int r;
        logic [15:0] v;
        case (o)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x ^ y;
            3'd3: return ~x;
            3'd4: return ~(x & y);
            3'd5: return ~(x | y);
            3'd6: r = s % 8;
            default: r = (8 - s) % 8;
        endcase
        v = {8'h00, x} << r;
        return v[7:0] | v[15:8];
    endfunction

    // Called at a negedge: presents a request for exactly one rising edge.
    task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input logic [2:0] s);
        start = 1'b1; op = o; a = x; b = y; shamt = s;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); shamt = 3'($urandom); op = 3'($urandom);
    endtask

    // Counts busy cycles until done is seen at a negedge, bounded.
    task automatic wait_done(output int nb, output bit ok);
        nb = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) nb++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({busy, done, result, zero} !== 11'd0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b result=%h zero=%b, required all 0", busy, done, result, zero);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, result, zero} !== 11'd0) begin
            errors++;
            $display("FAIL reset_hold: busy=%b done=%b result=%h zero=%b, required all 0", busy, done, result, zero);
        end
    endtask

    task automatic run_check(input string nm, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                             input logic [2:0] s);
        int nb, want_nb;
        bit ok;
        logic [7:0] exp;
        exp = model(o, x, y, s);
        want_nb = (o >= 3'd6) ? int'(s) : 0;
        issue(o, x, y, s);
        wait_done(nb, ok);
        checks++;
        if (!ok || result !== exp || zero !== (exp == 8'h00) || nb != want_nb) begin
            errors++;
            $display("FAIL %s: op=%0d a=%h b=%h s=%0d got done=%b result=%h zero=%b busy_cycles=%0d, required result=%h zero=%b busy_cycles=%0d",
                     nm, o, x, y, s, ok, result, zero, nb, exp, exp == 8'h00, want_nb);
        end
`ifdef LOGIC_UNIT_PARITY_EN
        checks++;
        if (parity !== ^exp) begin
            errors++;
            $display("FAIL %s_parity: got %b required %b", nm, parity, ^exp);
        end
`endif
    endtask

    task automatic test_bitwise;
        run_check("and", 3'd0, 8'hF0, 8'h3C, 3'd0);
        run_check("not", 3'd3, 8'h5A, 8'h00, 3'd0);
        run_check("ror0", 3'd7, 8'h5A, 8'h00, 3'd0);
        run_check("nand", 3'd4, 8'hFF, 8'hFF, 3'd0);
        run_check("or", 3'd1, 8'h00, 8'h00, 3'd0);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || result !== 8'h00 || zero !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse: done=%b result=%h zero=%b, required done=0 result=00 zero=1", done, result, zero);
        end
    endtask

    task automatic test_back_to_back;
        run_check("b2b_xor", 3'd2, 8'hA5, 8'hA5, 3'd0);
        run_check("b2b_nor", 3'd5, 8'h00, 8'h0F, 3'd0);
        run_check("b2b_rol", 3'd6, 8'h81, 8'h00, 3'd3);
        run_check("b2b_ror", 3'd7, 8'h0C, 8'h00, 3'd3);
        @(negedge clk);
    endtask

    task automatic test_rot_ignore_start;
        int nb;
        bit ok;
        issue(3'd6, 8'h01, 8'h00, 3'd7);
        start = 1'b1; op = 3'd0; a = 8'hFF; b = 8'hFF; shamt = 3'd0;
        @(negedge clk);
        start = 1'b0;
        wait_done(nb, ok);
        checks++;
        if (!ok || result !== 8'h80 || nb != 6) begin
            errors++;
            $display("FAIL rot_ignore: done=%b result=%h remaining_busy=%0d, required result=80 remaining_busy=6", ok, result, nb);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 8'h80) begin
            errors++;
            $display("FAIL rot_not_queued: done=%b busy=%b result=%h, required 0 0 80", done, busy, result);
        end
    endtask

    task automatic test_rot_reset;
        issue(3'd6, 8'h01, 8'h00, 3'd7);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rot_busy: busy=%b required 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, result, zero} !== 11'd0) begin
            errors++;
            $display("FAIL rot_abort: busy=%b done=%b result=%h zero=%b, required all 0", busy, done, result, zero);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: done=%b busy=%b required 0 0", done, busy);
        end
        run_check("after_rst_and", 3'd0, 8'hF0, 8'hFF, 3'd0);
        run_check("and07", 3'd0, 8'h07, 8'hFF, 3'd0);
        @(negedge clk);
    endtask

    task automatic test_random;
        for (int i = 0; i < 60; i++) begin
            run_check("rand", 3'($urandom), 8'($urandom), 8'($urandom), 3'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_bitwise;
        test_back_to_back;
        test_rot_ignore_start;
        test_rot_reset;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
